// File: rtl/filter_layer_sched.sv
// filter_layer_sched: per-layer weight load, pixel scan and pipeline drain sequencer
module filter_layer_sched #(
  parameter int LNUM = 3,
  parameter int WCOUNT = 64,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int PIPE_LAT = 4,
  parameter int AW = 16,
  localparam int LW = LNUM > 1 ? $clog2(LNUM) : 1,
  localparam int WW = WCOUNT > 1 ? $clog2(WCOUNT) : 1,
  localparam int XW = IMG_W > 1 ? $clog2(IMG_W) : 1,
  localparam int YW = IMG_H > 1 ? $clog2(IMG_H) : 1,
  localparam int DW = PIPE_LAT > 1 ? $clog2(PIPE_LAT) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] layer,
  output logic          wmem_rd,
  output logic [AW-1:0] wmem_addr,
  output logic          coef_we,
  output logic [WW-1:0] coef_idx,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic          dp_en,
  output logic [XW-1:0] col,
  output logic [YW-1:0] row,
  output logic          out_valid,
  output logic          out_last,
  input  logic [LNUM-1:0] relu_mask,
  input  logic          cfg_clip,
  output logic          relu,
  output logic          clip
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, LWAIT = 3'd2, RUN = 3'd3, DRAIN = 3'd4, DONE = 3'd5;
  localparam logic [LW-1:0] L_LAST = LW'(LNUM - 1);
  localparam logic [WW-1:0] W_LAST = WW'(WCOUNT - 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);
  logic [2:0] state;
  logic [WW-1:0] wcnt;
  logic [DW-1:0] dcnt;
  logic [PIPE_LAT-1:0] vpipe, lpipe;
  logic end_px;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign wmem_rd = state == LOAD;
  assign pix_ready = state == RUN;
  assign dp_en = pix_ready & pix_valid;
  assign end_px = col == X_LAST && row == Y_LAST;
  assign wmem_addr = AW'(layer) * AW'(WCOUNT) + AW'(wcnt);
  assign out_valid = vpipe[PIPE_LAT-1];
  assign out_last = lpipe[PIPE_LAT-1];
  assign relu = relu_mask[layer];
  assign clip = cfg_clip;
  // Sequencer: load weights, scan the frame, drain the datapath, repeat per layer
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      layer <= '0;
      wcnt <= '0;
      dcnt <= '0;
      col <= '0;
      row <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          layer <= '0;
          wcnt <= '0;
          state <= LOAD;
        end
        LOAD: begin
          wcnt <= wcnt == W_LAST ? '0 : wcnt + 1'b1;
          state <= wcnt == W_LAST ? LWAIT : LOAD;
        end
        LWAIT: state <= RUN;
        RUN: if (dp_en) begin
          col <= col == X_LAST ? '0 : col + 1'b1;
          row <= end_px ? '0 : col == X_LAST ? row + 1'b1 : row;
          dcnt <= '0;
          state <= end_px ? DRAIN : RUN;
        end
        DRAIN: begin
          dcnt <= dcnt == D_LAST ? '0 : dcnt + 1'b1;
          if (dcnt == D_LAST) begin
            state <= layer == L_LAST ? DONE : LOAD;
            layer <= layer == L_LAST ? layer : layer + 1'b1;
            wcnt <= '0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // Read-return strobe and the fixed-latency valid/last pipes; reset flushes in-flight pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      coef_we <= 1'b0;
      coef_idx <= '0;
      vpipe <= '0;
      lpipe <= '0;
    end else begin
      coef_we <= wmem_rd;
      coef_idx <= wcnt;
      vpipe <= (vpipe << 1) | PIPE_LAT'(dp_en);
      lpipe <= (lpipe << 1) | PIPE_LAT'(dp_en & end_px);
    end
  end
endmodule

// File: tb/tb_filter_layer_sched.sv
// tb_filter_layer_sched: schedule-model checks of the layer sequencer
module tb_filter_layer_sched;
  localparam int LN = 2, WC = 4, IW = 3, IH = 2, PL = 2;
  logic clk = 1'b0, reset, start, pix_valid, cfg_clip;
  logic [1:0] relu_mask;
  logic busy, done, wmem_rd, coef_we, pix_ready, dp_en, out_valid, out_last, relu, clip;
  logic [0:0] layer, row;
  logic [15:0] wmem_addr;
  logic [1:0] coef_idx, col;
  int passed = 0, total = 0;
  bit pv[0:127], st[0:127];
  bit e_busy[0:127], e_rd[0:127], e_we[0:127], e_ready[0:127], e_dp[0:127], e_lin[0:127], e_ov[0:127], e_ol[0:127], e_done[0:127];
  int e_layer[0:127], e_addr[0:127], e_idx[0:127], e_col[0:127], e_row[0:127];
  int done_t;

  filter_layer_sched #(.LNUM(LN), .WCOUNT(WC), .IMG_W(IW), .IMG_H(IH), .PIPE_LAT(PL), .AW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .layer(layer),
    .wmem_rd(wmem_rd), .wmem_addr(wmem_addr), .coef_we(coef_we), .coef_idx(coef_idx),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .dp_en(dp_en), .col(col), .row(row),
    .out_valid(out_valid), .out_last(out_last), .relu_mask(relu_mask), .cfg_clip(cfg_clip),
    .relu(relu), .clip(clip)
  );

  always #5 clk = ~clk;

  // Expected schedule: phases laid out in time, then the 1-cycle read return and PL-cycle output delay
  task automatic build(input int mode);
    int t, k;
    for (int i = 0; i < 128; i++) begin
      {e_busy[i], e_rd[i], e_we[i], e_ready[i], e_dp[i], e_lin[i], e_ov[i], e_ol[i], e_done[i]} = '0;
      e_layer[i] = 0; e_addr[i] = 0; e_idx[i] = 0; e_col[i] = 0; e_row[i] = 0;
      pv[i] = mode == 0 ? 1'b1 : mode == 1 ? (i % 2 == 0) : ($urandom_range(0, 3) != 0);
    end
    t = 1;
    for (int l = 0; l < LN; l++) begin
      for (int w = 0; w < WC; w++) begin
        e_busy[t] = 1; e_layer[t] = l; e_rd[t] = 1; e_addr[t] = l * WC + w; t++;
      end
      e_busy[t] = 1; e_layer[t] = l; t++;
      k = 0;
      while (k < IW * IH) begin
        if (t > 100) pv[t] = 1'b1;
        e_busy[t] = 1; e_layer[t] = l; e_ready[t] = 1;
        if (pv[t]) begin
          e_dp[t] = 1; e_col[t] = k % IW; e_row[t] = k / IW; e_lin[t] = (k == IW * IH - 1); k++;
        end
        t++;
      end
      for (int d = 0; d < PL; d++) begin
        e_busy[t] = 1; e_layer[t] = l; t++;
      end
    end
    e_busy[t] = 1; e_layer[t] = LN - 1; e_done[t] = 1; done_t = t;
    for (int i = 1; i < 128; i++) begin
      e_we[i] = e_rd[i-1]; e_idx[i] = e_addr[i-1] % WC;
      if (i >= PL) begin e_ov[i] = e_dp[i-PL]; e_ol[i] = e_lin[i-PL]; end
    end
    for (int i = 0; i < 128; i++) st[i] = mode == 2 && i >= 1 && i < done_t && $urandom_range(0, 3) == 0;
  endtask

  // Drives one pass and compares every cycle against the schedule; optional reset at cycle rst_t
  task automatic run_pass(input int rst_t, output int dut_done);
    dut_done = -1;
    reset = 0; start = 1; pix_valid = pv[0];
    @(posedge clk);
    for (int t = 1; t <= done_t + 3; t++) begin
      #1; start = st[t]; pix_valid = pv[t]; reset = (t == rst_t);
      #1;
      if (rst_t != 0 && t > rst_t) begin
        total++; if ({busy, done, layer, wmem_rd, coef_we, dp_en, pix_ready, out_valid, out_last} !== 9'b0) $display("FAIL post_reset t=%0d got %b required 0", t, {busy, done, layer, wmem_rd, coef_we, dp_en, pix_ready, out_valid, out_last}); else passed++;
        if (t >= rst_t + 4) break;
      end else begin
        total++; if (busy !== e_busy[t]) $display("FAIL busy t=%0d got %b required %b", t, busy, e_busy[t]); else passed++;
        total++; if (done !== e_done[t]) $display("FAIL done t=%0d got %b required %b", t, done, e_done[t]); else passed++;
        total++; if (wmem_rd !== e_rd[t]) $display("FAIL wmem_rd t=%0d got %b required %b", t, wmem_rd, e_rd[t]); else passed++;
        total++; if (coef_we !== e_we[t]) $display("FAIL coef_we t=%0d got %b required %b", t, coef_we, e_we[t]); else passed++;
        total++; if (pix_ready !== e_ready[t]) $display("FAIL pix_ready t=%0d got %b required %b", t, pix_ready, e_ready[t]); else passed++;
        total++; if (dp_en !== e_dp[t]) $display("FAIL dp_en t=%0d got %b required %b", t, dp_en, e_dp[t]); else passed++;
        total++; if (out_valid !== e_ov[t]) $display("FAIL out_valid t=%0d got %b required %b", t, out_valid, e_ov[t]); else passed++;
        total++; if (out_last !== e_ol[t]) $display("FAIL out_last t=%0d got %b required %b", t, out_last, e_ol[t]); else passed++;
        total++; if (clip !== cfg_clip) $display("FAIL clip t=%0d got %b required %b", t, clip, cfg_clip); else passed++;
        if (e_busy[t]) begin
          total++; if (32'(layer) !== e_layer[t]) $display("FAIL layer t=%0d got %0d required %0d", t, layer, e_layer[t]); else passed++;
          total++; if (relu !== relu_mask[e_layer[t]]) $display("FAIL relu t=%0d got %b required %b", t, relu, relu_mask[e_layer[t]]); else passed++;
        end
        if (e_rd[t]) begin
          total++; if (32'(wmem_addr) !== e_addr[t]) $display("FAIL wmem_addr t=%0d got %0d required %0d", t, wmem_addr, e_addr[t]); else passed++;
        end
        if (e_we[t]) begin
          total++; if (32'(coef_idx) !== e_idx[t]) $display("FAIL coef_idx t=%0d got %0d required %0d", t, coef_idx, e_idx[t]); else passed++;
        end
        if (e_dp[t]) begin
          total++; if (32'(col) !== e_col[t] || 32'(row) !== e_row[t]) $display("FAIL col_row t=%0d got (%0d,%0d) required (%0d,%0d)", t, col, row, e_col[t], e_row[t]); else passed++;
        end
      end
      if (done === 1'b1 && dut_done < 0) dut_done = t;
      @(posedge clk);
    end
    #1; reset = 0; start = 0;
  endtask

  task automatic test_reset();
    reset = 1; start = 0; pix_valid = 1; relu_mask = 2'b01; cfg_clip = 1;
    repeat (2) @(posedge clk);
    #1; reset = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({busy, done, layer, wmem_rd, coef_we, dp_en, pix_ready, out_valid, out_last} !== 9'b0) $display("FAIL reset_state got %b required 0", {busy, done, layer, wmem_rd, coef_we, dp_en, pix_ready, out_valid, out_last}); else passed++;
      total++; if (relu !== 1'b1 || clip !== 1'b1) $display("FAIL reset_relu_clip got %b%b required 11", relu, clip); else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    int d;
    relu_mask = 2'b10; cfg_clip = 0;
    build(0);
    run_pass(0, d);
    total++; if (d !== 27) $display("FAIL basic_done_cycle got %0d required 27", d); else passed++;
  endtask

  task automatic test_stall();
    int d;
    relu_mask = 2'b01; cfg_clip = 1;
    build(1);
    run_pass(0, d);
    total++; if (d !== done_t) $display("FAIL stall_done_cycle got %0d required %0d", d, done_t); else passed++;
  endtask

  task automatic test_random();
    int d;
    for (int r = 0; r < 4; r++) begin
      relu_mask = 2'($urandom); cfg_clip = 1'($urandom);
      build(2);
      run_pass(0, d);
      total++; if (d !== done_t) $display("FAIL random_done_cycle r=%0d got %0d required %0d", r, d, done_t); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int d;
    relu_mask = 2'b11; cfg_clip = 0;
    build(0);
    run_pass(21, d);
    total++; if (d !== -1) $display("FAIL reset_mid_done got %0d required -1", d); else passed++;
  endtask

  initial begin
    reset = 1; start = 0; pix_valid = 0; relu_mask = '0; cfg_clip = 0;
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_reset_mid();
    test_basic();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
